// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: periodic multi-channel I2C ADC scan sequencer with watchdog and error flags.
// Define ADC_AVG_EN to average four conversion reads per channel.
module adc_scan_ctrl #(
    parameter int          CH_NUM      = 4,
    parameter logic [6:0]  DEV_ID      = 7'h20,
    parameter logic [7:0]  CFG_REG     = 8'h02,
    parameter logic [7:0]  CONV_REG    = 8'h00,
    parameter int          PERIOD_CYC  = 50000,
    parameter int          TIMEOUT_CYC = 200000
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst_n,
    input  logic        i_scan_en,
    input  logic        i_scan_once,
    input  logic [3:0]  i_ch_mask,
    output logic        o_adc_wr_req,
    output logic        o_adc_rd_req,
    output logic [6:0]  o_adc_device_id,
    output logic [7:0]  o_adc_reg_addr,
    output logic        o_adc_reg_addr_vld,
    output logic [7:0]  o_adc_wr_data,
    output logic        o_adc_wr_data_vld,
    input  logic [11:0] i_adc_rd_data,
    input  logic        i_adc_rd_data_vld,
    input  logic        i_adc_ready,
    output logic [11:0] o_ch_data,
    output logic [1:0]  o_ch_idx,
    output logic        o_ch_vld,
    output logic        o_scan_done,
    output logic        o_busy,
    output logic        o_err_timeout,
    output logic        o_err_nodata
);
    localparam logic [3:0] VALID = 4'((1 << CH_NUM) - 1);
    typedef enum logic [2:0] {IDLE, WAIT_PERIOD, CFG_REQ, CFG_WAIT, RD_REQ, RD_WAIT, STORE, NEXT} state_t;
    state_t      r_state;
    logic [1:0]  r_ch, r_ch_idx;
    logic [3:0]  r_pend;
    logic [31:0] r_per_cnt, r_wd;
    logic        r_seen_low, r_have;
    logic [11:0] r_data, r_ch_data;
    logic [7:0]  r_reg_addr, r_wr_data;
    logic        r_wr_req, r_rd_req, r_addr_vld, r_wr_vld, r_ch_vld, r_scan_done, r_busy, r_err_timeout, r_err_nodata;
`ifdef ADC_AVG_EN
    logic [13:0] r_sum;
    logic [1:0]  r_rd_cnt;
`endif
    logic [3:0]  w_mask;
    logic        w_start, w_done, w_wd_exp, w_have;
    logic [11:0] w_data;
    state_t      w_end_state;
    function automatic logic [1:0] f_low(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction
    assign w_mask      = i_ch_mask & VALID;
    assign w_start     = (r_state == IDLE && (i_scan_en || i_scan_once)) ||
                         (r_state == WAIT_PERIOD && i_scan_en && r_per_cnt == 32'(PERIOD_CYC - 1));
    // a transaction completes when ready returns high after having dropped
    assign w_done      = r_seen_low && i_adc_ready;
    assign w_wd_exp    = r_wd == 32'(TIMEOUT_CYC - 1);
    assign w_have      = r_have || i_adc_rd_data_vld;
    assign w_data      = i_adc_rd_data_vld ? i_adc_rd_data : r_data;
    assign w_end_state = i_scan_en ? WAIT_PERIOD : IDLE;
    assign o_adc_device_id = DEV_ID;
    assign {o_adc_wr_req, o_adc_rd_req, o_adc_reg_addr, o_adc_reg_addr_vld, o_adc_wr_data, o_adc_wr_data_vld} =
           {r_wr_req, r_rd_req, r_reg_addr, r_addr_vld, r_wr_data, r_wr_vld};
    assign {o_ch_data, o_ch_idx, o_ch_vld, o_scan_done, o_busy, o_err_timeout, o_err_nodata} =
           {r_ch_data, r_ch_idx, r_ch_vld, r_scan_done, r_busy, r_err_timeout, r_err_nodata};
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            r_state       <= IDLE;
            r_ch          <= '0;
            r_pend        <= '0;
            r_per_cnt     <= '0;
            r_wd          <= '0;
            r_seen_low    <= 1'b0;
            r_have        <= 1'b0;
            r_data        <= '0;
            r_reg_addr    <= '0;
            r_wr_data     <= '0;
            r_ch_data     <= '0;
            r_ch_idx      <= '0;
            {r_wr_req, r_rd_req, r_addr_vld, r_wr_vld, r_ch_vld, r_scan_done, r_busy} <= '0;
            {r_err_timeout, r_err_nodata} <= '0;
`ifdef ADC_AVG_EN
            r_sum         <= '0;
            r_rd_cnt      <= '0;
`endif
        end else begin
            {r_wr_req, r_rd_req, r_addr_vld, r_wr_vld, r_ch_vld, r_scan_done} <= '0;
            r_per_cnt <= (r_per_cnt == 32'(PERIOD_CYC - 1)) ? r_per_cnt : r_per_cnt + 1;
            if (w_start) begin
                r_per_cnt <= '0;
                r_ch      <= f_low(w_mask);
                r_pend    <= w_mask & (w_mask - 4'd1);
                if (w_mask == 4'd0) begin
                    r_scan_done <= 1'b1;
                    r_state     <= w_end_state;
                end else begin
                    r_busy  <= 1'b1;
                    r_state <= CFG_REQ;
                end
            end else begin
                case (r_state)
                    WAIT_PERIOD: if (!i_scan_en) r_state <= IDLE;
                    CFG_REQ: if (i_adc_ready) begin
                        {r_wr_req, r_addr_vld, r_wr_vld} <= 3'b111;
                        r_reg_addr <= CFG_REG;
                        r_wr_data  <= 8'h10 << r_ch;
                        r_wd       <= '0;
                        r_seen_low <= 1'b0;
`ifdef ADC_AVG_EN
                        r_sum      <= '0;
                        r_rd_cnt   <= '0;
`endif
                        r_state    <= CFG_WAIT;
                    end
                    CFG_WAIT: begin
                        if (!i_adc_ready) r_seen_low <= 1'b1;
                        r_wd <= r_wd + 1;
                        if (w_done) r_state <= RD_REQ;
                        else if (w_wd_exp) begin
                            {r_err_timeout, r_scan_done} <= 2'b11;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    RD_REQ: if (i_adc_ready) begin
                        {r_rd_req, r_addr_vld} <= 2'b11;
                        r_reg_addr <= CONV_REG;
                        r_wd       <= '0;
                        r_seen_low <= 1'b0;
                        r_have     <= 1'b0;
                        r_state    <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (!i_adc_ready) r_seen_low <= 1'b1;
                        if (i_adc_rd_data_vld) {r_have, r_data} <= {1'b1, i_adc_rd_data};
                        r_wd <= r_wd + 1;
                        if (w_done && !w_have) begin
                            r_err_nodata <= 1'b1;
                            r_state      <= NEXT;
                        end else if (w_done) begin
`ifdef ADC_AVG_EN
                            r_sum    <= r_sum + 14'(w_data);
                            r_rd_cnt <= r_rd_cnt + 2'd1;
                            r_state  <= (r_rd_cnt == 2'd3) ? STORE : RD_REQ;
`else
                            r_state  <= STORE;
`endif
                        end else if (w_wd_exp) begin
                            {r_err_timeout, r_scan_done} <= 2'b11;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    STORE: begin
                        r_ch_vld  <= 1'b1;
                        r_ch_idx  <= r_ch;
`ifdef ADC_AVG_EN
                        r_ch_data <= 12'(r_sum >> 2);
`else
                        r_ch_data <= r_data;
`endif
                        r_state   <= NEXT;
                    end
                    NEXT: if (r_pend != 4'd0) begin
                        r_ch    <= f_low(r_pend);
                        r_pend  <= r_pend & (r_pend - 4'd1);
                        r_state <= CFG_REQ;
                    end else begin
                        r_scan_done <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= w_end_state;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: randomized scoreboard bench with a behavioural ADC responder.
module tb_adc_scan_ctrl;
    localparam int         PER  = 1000;
    localparam int         TMO  = 500;
    localparam logic [7:0] CFG  = 8'h02;
    localparam logic [7:0] CONV = 8'h00;
    logic        clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0, scan_once = 1'b0;
    logic [3:0]  ch_mask = '0;
    logic [11:0] rd_data = '0;
    logic        rd_vld = 1'b0, ready = 1'b1;
    logic        o_adc_wr_req, o_adc_rd_req, o_adc_reg_addr_vld, o_adc_wr_data_vld;
    logic [6:0]  o_adc_device_id;
    logic [7:0]  o_adc_reg_addr, o_adc_wr_data;
    logic [11:0] o_ch_data;
    logic [1:0]  o_ch_idx;
    logic        o_ch_vld, o_scan_done, o_busy, o_err_timeout, o_err_nodata;

    adc_scan_ctrl #(.CH_NUM(4), .DEV_ID(7'h20), .CFG_REG(CFG), .CONV_REG(CONV),
                    .PERIOD_CYC(PER), .TIMEOUT_CYC(TMO)) dut (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_scan_en(scan_en), .i_scan_once(scan_once),
        .i_ch_mask(ch_mask), .o_adc_wr_req(o_adc_wr_req), .o_adc_rd_req(o_adc_rd_req),
        .o_adc_device_id(o_adc_device_id), .o_adc_reg_addr(o_adc_reg_addr),
        .o_adc_reg_addr_vld(o_adc_reg_addr_vld), .o_adc_wr_data(o_adc_wr_data),
        .o_adc_wr_data_vld(o_adc_wr_data_vld), .i_adc_rd_data(rd_data),
        .i_adc_rd_data_vld(rd_vld), .i_adc_ready(ready), .o_ch_data(o_ch_data),
        .o_ch_idx(o_ch_idx), .o_ch_vld(o_ch_vld), .o_scan_done(o_scan_done), .o_busy(o_busy),
        .o_err_timeout(o_err_timeout), .o_err_nodata(o_err_nodata));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;
    logic [11:0] val[4];
    int nodata_ch = -1, fix_lat = 0;
    bit hang = 1'b0, rd_seen = 1'b0, prev_busy = 1'b0;
    int off[4] = '{0, 1, 2, 4};
    logic [7:0]  exp_cfg[$];
    logic [13:0] exp_res[$];
    int busy_rise[$];
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, last_wr_cyc = 0, last_done_cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // expected channel result: plain value, or truncated mean of the four offset reads
    function automatic logic [11:0] ref_val(input logic [11:0] v);
`ifdef ADC_AVG_EN
        int s = 0;
        for (int k = 0; k < 4; k++) s += int'(v) + off[k];
        return 12'(s / 4);
`else
        return v;
`endif
    endfunction

    task automatic expect_scan(input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) begin
                exp_cfg.push_back(8'(8'h10 << i));
                if (i != nodata_ch) exp_res.push_back({2'(i), ref_val(val[i])});
            end
    endtask

    task automatic pulse_once(input logic [3:0] m);
        @(negedge clk);
        ch_mask = m;
        scan_once = 1'b1;
        @(negedge clk);
        scan_once = 1'b0;
    endtask

    task automatic wait_done(input int start, input int n, input int bound, input string name);
        int k = 0;
        while (done_cnt < start + n && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_done"}, 64'(done_cnt - start), 64'(n));
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({o_adc_wr_req, o_adc_rd_req, o_adc_reg_addr, o_adc_reg_addr_vld, o_adc_wr_data,
                         o_adc_wr_data_vld, o_ch_data, o_ch_idx, o_ch_vld, o_scan_done, o_busy,
                         o_err_timeout, o_err_nodata}), 64'd0);
        check({name, "_dev_id"}, 64'(o_adc_device_id), 64'h20);
    endtask

    // ADC access block model
    initial begin
        bit is_rd;
        int ch = 0, rdi = 0, lat;
        forever begin
            @(negedge clk);
            if (o_adc_wr_req || o_adc_rd_req) begin
                is_rd = o_adc_rd_req;
                if (!is_rd) begin
                    for (int i = 0; i < 4; i++) if (o_adc_wr_data == 8'(8'h10 << i)) ch = i;
                    rdi = 0;
                end
                ready = 1'b0;
                lat = (fix_lat != 0) ? fix_lat : int'($urandom_range(2, 12));
                repeat (lat) @(negedge clk);
                if (is_rd && ch != nodata_ch) begin
`ifdef ADC_AVG_EN
                    rd_data = 12'(int'(val[ch]) + off[rdi % 4]);
`else
                    rd_data = val[ch];
`endif
                    rd_vld = 1'b1;
                    @(negedge clk);
                    rd_vld = 1'b0;
                end
                if (is_rd) rdi++;
                while (hang) @(negedge clk);
                ready = 1'b1;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (o_adc_wr_req) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                check("wr_addr_vld", 64'(o_adc_reg_addr_vld), 64'd1);
                check("wr_data_vld", 64'(o_adc_wr_data_vld), 64'd1);
                check("wr_reg_addr", 64'(o_adc_reg_addr), 64'(CFG));
                if (exp_cfg.size() == 0) check("unexpected_wr", 64'(o_adc_wr_data), 64'hFFFF);
                else check("wr_data", 64'(o_adc_wr_data), 64'(exp_cfg.pop_front()));
            end
            if (o_adc_rd_req) begin
                rd_cnt++;
                rd_seen = 1'b1;
                check("rd_addr_vld", 64'(o_adc_reg_addr_vld), 64'd1);
                check("rd_reg_addr", 64'(o_adc_reg_addr), 64'(CONV));
            end
            if (o_ch_vld) begin
                if (exp_res.size() == 0) check("unexpected_ch", 64'({o_ch_idx, o_ch_data}), 64'hFFFF);
                else check("ch_result", 64'({o_ch_idx, o_ch_data}), 64'(exp_res.pop_front()));
            end
            if (o_scan_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (o_busy && !prev_busy) busy_rise.push_back(cyc);
            prev_busy = o_busy;
        end
    end

    initial begin
        int d, r0;
        logic [3:0] m;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // directed: channels 0 and 2, second scan_once while busy is ignored
        val[0] = 12'hABC; val[1] = 12'h555; val[2] = 12'h123; val[3] = 12'h777;
        expect_scan(4'b0101);
        d = done_cnt;
        pulse_once(4'b0101);
        repeat (20) @(negedge clk);
        pulse_once(4'b1111);
        wait_done(d, 1, 3000, "directed");
        repeat (50) @(negedge clk);
        check("directed_single_done", 64'(done_cnt - d), 64'd1);
        check("directed_busy", 64'(o_busy), 64'd0);
        check("directed_left", 64'(exp_res.size() + exp_cfg.size()), 64'd0);

        // random masks and values, first one empty
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) val[k] = 12'($urandom_range(0, 12'hFF0));
            m = (i == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            r0 = wr_cnt;
            expect_scan(m);
            d = done_cnt;
            pulse_once(m);
            wait_done(d, 1, 3000, "rand");
            repeat (5) @(negedge clk);
            check("rand_wr_count", 64'(wr_cnt - r0), 64'($countones(m)));
            check("rand_left", 64'(exp_res.size() + exp_cfg.size()), 64'd0);
            check("rand_busy", 64'(o_busy), 64'd0);
        end
        check("no_err_nodata_yet", 64'(o_err_nodata), 64'd0);

        // read without data on channel 1
        nodata_ch = 1;
        expect_scan(4'b0011);
        d = done_cnt;
        pulse_once(4'b0011);
        wait_done(d, 1, 3000, "nodata");
        repeat (5) @(negedge clk);
        check("err_nodata", 64'(o_err_nodata), 64'd1);
        check("nodata_left", 64'(exp_res.size() + exp_cfg.size()), 64'd0);
        nodata_ch = -1;

        // continuous scanning paced by the period counter
        for (int k = 0; k < 4; k++) val[k] = 12'($urandom_range(0, 12'hFF0));
        repeat (3) expect_scan(4'b1111);
        busy_rise.delete();
        d = done_cnt;
        @(negedge clk);
        ch_mask = 4'b1111;
        scan_en = 1'b1;
        wait_done(d, 3, 4000, "periodic");
        repeat (100) @(negedge clk);
        scan_en = 1'b0;
        r0 = wr_cnt + rd_cnt;
        repeat (1500) @(negedge clk);
        check("periodic_quiet", 64'(wr_cnt + rd_cnt - r0), 64'd0);
        check("periodic_busy", 64'(o_busy), 64'd0);
        check("periodic_starts", 64'(busy_rise.size()), 64'd3);
        if (busy_rise.size() >= 3) begin
            check("period_1", 64'(busy_rise[1] - busy_rise[0]), 64'(PER));
            check("period_2", 64'(busy_rise[2] - busy_rise[1]), 64'(PER));
        end
        check("periodic_left", 64'(exp_res.size() + exp_cfg.size()), 64'd0);

        // watchdog: ADC never returns ready
        hang = 1'b1;
        exp_cfg.push_back(8'h10);
        d = done_cnt;
        pulse_once(4'b0001);
        wait_done(d, 1, 2000, "timeout");
        check("err_timeout", 64'(o_err_timeout), 64'd1);
        check("timeout_busy", 64'(o_busy), 64'd0);
        check("timeout_cycles", 64'(last_done_cyc - last_wr_cyc), 64'(TMO));
        hang = 1'b0;
        repeat (20) @(negedge clk);

        // reset in the middle of a read
        fix_lat = 40;
        rd_seen = 1'b0;
        exp_cfg.push_back(8'h10);
        pulse_once(4'b0001);
        for (int k = 0; k < 500 && !rd_seen; k++) @(negedge clk);
        check("rd_seen", 64'(rd_seen), 64'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        r0 = wr_cnt + rd_cnt;
        repeat (100) @(negedge clk);
        check("post_reset_quiet", 64'(wr_cnt + rd_cnt - r0), 64'd0);
        check("post_reset_busy", 64'(o_busy), 64'd0);
        check("final_left", 64'(exp_res.size() + exp_cfg.size()), 64'd0);
        fix_lat = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
